// File: rtl/ece571_cpu_pkg.sv
// Shared types for the ece571 CPU slice: ALU opcodes, controller FSM states
// and the packed instruction layout used by the issue/writeback controller.
package ece571_cpu_pkg;

   localparam int DEF_NREGS = 8;
   localparam int DEF_RW    = $clog2(DEF_NREGS);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic [2:0]        op;
      logic [DEF_RW-1:0] rd;
      logic [DEF_RW-1:0] rs1;
      logic [DEF_RW-1:0] rs2;
   } instr_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= 3'd4);
   endfunction

endpackage

// File: rtl/ece571_regfile.sv
// NREGS x N register file: two asynchronous read ports, a writeback port and a
// preload port. Writeback beats preload on the same index; r0 always reads 0.
module ece571_regfile #(
   parameter int N     = 32,
   parameter int NREGS = 8,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] rd_addr1_i,
   output logic [N-1:0]  rd_data1_o,
   input  logic [RW-1:0] rd_addr2_i,
   output logic [N-1:0]  rd_data2_o,
   input  logic          wb_en_i,
   input  logic [RW-1:0] wb_addr_i,
   input  logic [N-1:0]  wb_data_i,
   input  logic          ld_en_i,
   input  logic [RW-1:0] ld_addr_i,
   input  logic [N-1:0]  ld_data_i
);

   logic [N-1:0] regs_q [NREGS];

   // Entry 0 is only ever cleared; the loop starts at 1 so nothing can write it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (wb_en_i && (wb_addr_i == RW'(i))) begin
               regs_q[i] <= wb_data_i;
            end else if (ld_en_i && (ld_addr_i == RW'(i))) begin
               regs_q[i] <= ld_data_i;
            end
         end
      end
   end

   assign rd_data1_o = (rd_addr1_i == '0) ? '0 : regs_q[rd_addr1_i];
   assign rd_data2_o = (rd_addr2_i == '0) ? '0 : regs_q[rd_addr2_i];

endmodule

// File: rtl/ece571_alu_ctrl.sv
// Issue/writeback controller for the ece571 ALU: accepts one instruction, reads
// operands, drives the ALU for one cycle, writes back and returns a response.
module ece571_alu_ctrl
   import ece571_cpu_pkg::*;
#(
   parameter int N     = 32,
   parameter int NREGS = DEF_NREGS,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3+3*RW-1:0] instr,
   input  logic              ld_valid,
   input  logic [RW-1:0]     ld_addr,
   input  logic [N-1:0]      ld_data,
   output opcode_t           alu_opcode,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   input  logic [N-1:0]      alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N-1:0]      rsp_data,
   output logic [RW-1:0]     rsp_rd,
   output logic              rsp_err,
   output logic              busy
);

   ctrl_state_t   state_q, state_d;
   opcode_t       alu_opcode_q, alu_opcode_d;
   logic [N-1:0]  alu_a_q, alu_a_d;
   logic [N-1:0]  alu_b_q, alu_b_d;
   logic [RW-1:0] rd_q, rd_d;
   logic          legal_q, legal_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [N-1:0]  rsp_data_q, rsp_data_d;
   logic [RW-1:0] rsp_rd_q, rsp_rd_d;
   logic          rsp_err_q, rsp_err_d;

   logic [2:0]    op_in;
   logic [RW-1:0] rd_in, rs1_in, rs2_in;
   logic [N-1:0]  rs1_val, rs2_val;
   logic          wb_en;
   logic          ready_c;

   assign op_in  = instr[3+3*RW-1 -: 3];
   assign rd_in  = instr[3*RW-1 -: RW];
   assign rs1_in = instr[2*RW-1 -: RW];
   assign rs2_in = instr[RW-1:0];

   ece571_regfile #(.N(N), .NREGS(NREGS)) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .rd_addr1_i (rs1_in),
      .rd_data1_o (rs1_val),
      .rd_addr2_i (rs2_in),
      .rd_data2_o (rs2_val),
      .wb_en_i    (wb_en),
      .wb_addr_i  (rd_q),
      .wb_data_i  (alu_result),
      .ld_en_i    (ld_valid),
      .ld_addr_i  (ld_addr),
      .ld_data_i  (ld_data)
   );

   // Illegal opcodes are steered to ADD so the ALU never sees an undefined code.
   always_comb begin
      state_d      = state_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rd_d         = rd_q;
      legal_d      = legal_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_rd_d     = rsp_rd_q;
      rsp_err_d    = rsp_err_q;
      wb_en        = 1'b0;
      ready_c      = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (instr_valid) begin
               legal_d      = is_legal_op(op_in);
               alu_opcode_d = is_legal_op(op_in) ? opcode_t'(op_in) : OP_ADD;
               rd_d         = rd_in;
               alu_a_d      = rs1_val;
               alu_b_d      = rs2_val;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            wb_en       = legal_q && (rd_q != '0);
            rsp_valid_d = 1'b1;
            rsp_data_d  = legal_q ? alu_result : '0;
            rsp_err_d   = !legal_q;
            rsp_rd_d    = rd_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         alu_opcode_q <= OP_ADD;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rd_q         <= '0;
         legal_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_rd_q     <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rd_q         <= rd_d;
         legal_q      <= legal_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_rd_q     <= rsp_rd_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign instr_ready = ready_c;
   assign alu_opcode  = alu_opcode_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_rd      = rsp_rd_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ece571_alu_ctrl.sv
// Directed testbench for ece571_alu_ctrl with a behavioural stand-in for the
// ALU; register contents are read back through OR rd=0 instructions.
module tb_ece571_alu_ctrl;
   import ece571_cpu_pkg::*;

   localparam int N  = 32;
   localparam int RW = DEF_RW;

   logic              clk;
   logic              reset;
   logic              instr_valid;
   logic              instr_ready;
   logic [3+3*RW-1:0] instr;
   logic              ld_valid;
   logic [RW-1:0]     ld_addr;
   logic [N-1:0]      ld_data;
   opcode_t           alu_opcode;
   logic [N-1:0]      alu_a;
   logic [N-1:0]      alu_b;
   logic [N-1:0]      alu_result;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_data;
   logic [RW-1:0]     rsp_rd;
   logic              rsp_err;
   logic              busy;

   int testCount = 0;
   int failCount = 0;

   ece571_alu_ctrl #(.N(N), .NREGS(DEF_NREGS)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .alu_opcode  (alu_opcode),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_rd      (rsp_rd),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   // Behavioural model of the existing combinational ALU
   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_AND:  alu_result = alu_a & alu_b;
         OP_OR:   alu_result = alu_a | alu_b;
         OP_XOR:  alu_result = alu_a ^ alu_b;
         default: alu_result = '0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic driveInstr(input logic [2:0] op, input logic [RW-1:0] rd,
                             input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
      instr_t v;
      v.op  = op;
      v.rd  = rd;
      v.rs1 = rs1;
      v.rs2 = rs2;
      instr = v;
   endtask

   task automatic preload(input logic [RW-1:0] addr, input logic [N-1:0] data);
      ld_valid = 1'b1;
      ld_addr  = addr;
      ld_data  = data;
      @(posedge clk); #1;
      ld_valid = 1'b0;
   endtask

   // Full issue/response sequence with rsp_ready held high
   task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [RW-1:0] rd,
                                input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                input logic [N-1:0] expA, input logic [N-1:0] expB,
                                input logic [2:0] expOp, input logic [N-1:0] expData,
                                input logic expErr);
      rsp_ready = 1'b1;
      driveInstr(op, rd, rs1, rs2);
      instr_valid = 1'b1;
      checkOutput({tag, ".instr_ready"}, 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checkOutput({tag, ".exec_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".alu_opcode"}, 32'(alu_opcode), 32'(expOp));
      checkOutput({tag, ".alu_a"}, alu_a, expA);
      checkOutput({tag, ".alu_b"}, alu_b, expB);
      @(posedge clk); #1;
      checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, ".rsp_data"}, rsp_data, expData);
      checkOutput({tag, ".rsp_rd"}, 32'(rsp_rd), 32'(rd));
      checkOutput({tag, ".rsp_err"}, 32'(rsp_err), 32'(expErr));
      @(posedge clk); #1;
      checkOutput({tag, ".idle_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic readReg(input string tag, input logic [RW-1:0] idx, input logic [N-1:0] expVal);
      applyStimulus(tag, 3'(OP_OR), '0, idx, '0, expVal, '0, 3'(OP_OR), expVal, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      ld_valid    = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
      rsp_ready   = 1'b1;

      @(posedge clk); @(posedge clk); #1;
      checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.alu_opcode", 32'(alu_opcode), 32'd0);
      checkOutput("reset.alu_a", alu_a, 32'd0);
      checkOutput("reset.rsp_data", rsp_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("post_reset.instr_ready", 32'(instr_ready), 32'd1);

      preload(3'd1, 32'h0000_0005);
      preload(3'd2, 32'h0000_0003);
      applyStimulus("add_r3", 3'(OP_ADD), 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 3'(OP_ADD), 32'd8, 1'b0);
      readReg("read_r3", 3'd3, 32'd8);

      applyStimulus("sub_r4", 3'(OP_SUB), 3'd4, 3'd2, 3'd1, 32'd3, 32'd5, 3'(OP_SUB), 32'hFFFF_FFFE, 1'b0);
      applyStimulus("xor_r5", 3'(OP_XOR), 3'd5, 3'd4, 3'd1, 32'hFFFF_FFFE, 32'd5, 3'(OP_XOR), 32'hFFFF_FFFB, 1'b0);
      readReg("read_r5", 3'd5, 32'hFFFF_FFFB);

      applyStimulus("illegal", 3'd6, 3'd1, 3'd2, 3'd2, 32'd3, 32'd3, 3'(OP_ADD), 32'd0, 1'b1);
      readReg("read_r1_after_illegal", 3'd1, 32'd5);

      // Backpressure: AND r6=r1&r2 while a second instruction is offered
      rsp_ready = 1'b0;
      driveInstr(3'(OP_AND), 3'd6, 3'd1, 3'd2);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      driveInstr(3'(OP_ADD), 3'd7, 3'd1, 3'd1);
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         checkOutput("stall.rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("stall.rsp_data", rsp_data, 32'd1);
         checkOutput("stall.rsp_rd", 32'(rsp_rd), 32'd6);
         checkOutput("stall.instr_ready", 32'(instr_ready), 32'd0);
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      rsp_ready   = 1'b1;
      @(posedge clk); #1;
      checkOutput("stall_release.busy", 32'(busy), 32'd0);
      checkOutput("stall_release.rsp_valid", 32'(rsp_valid), 32'd0);
      readReg("read_r6", 3'd6, 32'd1);
      readReg("read_r7_untouched", 3'd7, 32'd0);

      applyStimulus("or_r0", 3'(OP_OR), 3'd0, 3'd1, 3'd2, 32'd5, 32'd3, 3'(OP_OR), 32'd7, 1'b0);
      readReg("read_r0", 3'd0, 32'd0);

      // Preload and writeback both target r3 on the edge ending EXEC
      driveInstr(3'(OP_ADD), 3'd3, 3'd1, 3'd1);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      ld_valid = 1'b1;
      ld_addr  = 3'd3;
      ld_data  = 32'hAAAA_AAAA;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      checkOutput("collide.rsp_data", rsp_data, 32'd10);
      @(posedge clk); #1;
      readReg("read_r3_collide", 3'd3, 32'd10);

      // Preload of rs1 on the acceptance edge must not be bypassed
      driveInstr(3'(OP_ADD), 3'd6, 3'd1, 3'd0);
      instr_valid = 1'b1;
      ld_valid = 1'b1;
      ld_addr  = 3'd1;
      ld_data  = 32'h0000_0100;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      ld_valid = 1'b0;
      checkOutput("nobypass.alu_a", alu_a, 32'd5);
      @(posedge clk); #1;
      checkOutput("nobypass.rsp_data", rsp_data, 32'd5);
      @(posedge clk); #1;
      readReg("read_r1_preloaded", 3'd1, 32'h0000_0100);

      // Reset in the middle of EXEC
      driveInstr(3'(OP_ADD), 3'd2, 3'd1, 3'd1);
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checkOutput("midreset.pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midreset.busy", 32'(busy), 32'd0);
      checkOutput("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midreset.alu_a", alu_a, 32'd0);
      checkOutput("midreset.alu_b", alu_b, 32'd0);
      checkOutput("midreset.rsp_rd", 32'(rsp_rd), 32'd0);
      checkOutput("midreset.rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("midreset.no_rsp", 32'(rsp_valid), 32'd0);
      readReg("midreset.read_r1", 3'd1, 32'd0);
      readReg("midreset.read_r5", 3'd5, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
